// File: rtl/input_pin_conditioner_pkg.sv
// Shared sizing constants for the MPU341 input-pin conditioner.
// Pin count and debounce depth defaults used by the top and the bench.
package input_pin_conditioner_pkg;

    localparam int MPU341_IPIN_WIDTH       = 4;
    localparam int MPU341_DEBOUNCE_DEFAULT = 16;
    localparam int IPC_CNT_W_DEFAULT       = 8;

endpackage

// File: rtl/input_pin_conditioner_debounce_bit.sv
// One pin: 2-flop synchroniser, saturating debounce counter, stable level, edge pulses.
// Latency: change sampled into sync1 at edge k is accepted at edge k+1+DEBOUNCE_CYCLES.
// No backpressure; edge_nxt (INPUT_PIN_CONDITIONER_EDGE_LATCH_EN) flags the accept edge.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_async,
    output logic level,
    output logic rise,
    output logic fall
`ifdef INPUT_PIN_CONDITIONER_EDGE_LATCH_EN
    ,
    output logic edge_nxt
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // Accept on the edge that would complete DEBOUNCE_CYCLES consecutive differing samples.
    assign accept = (sync2 != level) && (cnt == CNT_LAST);

`ifdef INPUT_PIN_CONDITIONER_EDGE_LATCH_EN
    assign edge_nxt = accept;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= pin_async;
            sync2 <= sync1;
            rise  <= accept && sync2;
            fall  <= accept && !sync2;
            if (sync2 == level || accept) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (accept) begin
                level <= sync2;
            end
        end
    end

endmodule

// File: rtl/input_pin_conditioner.sv
// Conditions raw async pins for the MPU core i_pins bus: sync, per-bit debounce, edge pulses.
// Latency 1+DEBOUNCE_CYCLES edges from first sync1 sample; all outputs registered; no backpressure.
// Macro INPUT_PIN_CONDITIONER_EDGE_LATCH_EN adds sticky edge_flags with edge_clear.
module input_pin_conditioner
    import input_pin_conditioner_pkg::*;
#(
    parameter int WIDTH           = MPU341_IPIN_WIDTH,
    parameter int DEBOUNCE_CYCLES = MPU341_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = IPC_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pins_async,
    output logic [WIDTH-1:0] i_pins,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
`ifdef INPUT_PIN_CONDITIONER_EDGE_LATCH_EN
    ,
    input  logic [WIDTH-1:0] edge_clear,
    output logic [WIDTH-1:0] edge_flags
`endif
);

`ifdef INPUT_PIN_CONDITIONER_EDGE_LATCH_EN
    logic [WIDTH-1:0] edge_nxt;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_bit (
            .clk      (clk),
            .reset    (reset),
            .pin_async(pins_async[i]),
            .level    (i_pins[i]),
            .rise     (rise_pulse[i]),
            .fall     (fall_pulse[i])
`ifdef INPUT_PIN_CONDITIONER_EDGE_LATCH_EN
            ,
            .edge_nxt (edge_nxt[i])
`endif
        );
    end

`ifdef INPUT_PIN_CONDITIONER_EDGE_LATCH_EN
    // Flags set in the same cycle the pulse appears; a new edge beats a concurrent clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_flags <= '0;
        end else begin
            edge_flags <= edge_nxt | (edge_flags & ~edge_clear);
        end
    end
`endif

endmodule

// File: tb/tb_input_pin_conditioner.sv
// Randomised and directed checks of input_pin_conditioner against a sliding-window reference model.
module tb_input_pin_conditioner;

    localparam int W  = 4;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] pins_async = '0;
    logic [W-1:0] i_pins;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;
`ifdef INPUT_PIN_CONDITIONER_EDGE_LATCH_EN
    logic [W-1:0] edge_clear = '0;
    logic [W-1:0] edge_flags;
`endif

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    input_pin_conditioner #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pins_async(pins_async),
        .i_pins    (i_pins),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
`ifdef INPUT_PIN_CONDITIONER_EDGE_LATCH_EN
        ,
        .edge_clear(edge_clear),
        .edge_flags(edge_flags)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a pin level is accepted once the last DB synced samples all differ from it.
    logic [W-1:0]  m_s1 = '0, m_s2 = '0, m_stable = '0, m_rise = '0, m_fall = '0, m_flags = '0;
    logic [DB-1:0] hist [W];

    initial for (int b = 0; b < W; b++) hist[b] = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise = '0; m_fall = '0; m_flags = '0;
            for (int b = 0; b < W; b++) hist[b] = '0;
        end else begin
            m_rise = '0;
            m_fall = '0;
            for (int b = 0; b < W; b++) begin
                hist[b] = {hist[b][DB-2:0], m_s2[b]};
                if (hist[b] == (m_stable[b] ? {DB{1'b0}} : {DB{1'b1}})) begin
                    m_stable[b] = ~m_stable[b];
                    if (m_stable[b]) m_rise[b] = 1'b1;
                    else             m_fall[b] = 1'b1;
                end
`ifdef INPUT_PIN_CONDITIONER_EDGE_LATCH_EN
                if (m_rise[b] || m_fall[b]) m_flags[b] = 1'b1;
                else if (edge_clear[b])      m_flags[b] = 1'b0;
`endif
            end
            m_s2 = m_s1;
            m_s1 = pins_async;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("i_pins", 32'(i_pins), 32'(m_stable));
            chk("rise_pulse", 32'(rise_pulse), 32'(m_rise));
            chk("fall_pulse", 32'(fall_pulse), 32'(m_fall));
            chk("no_rise_and_fall", 32'(rise_pulse & fall_pulse), 32'd0);
`ifdef INPUT_PIN_CONDITIONER_EDGE_LATCH_EN
            chk("edge_flags", 32'(edge_flags), 32'(m_flags));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input logic [W-1:0] v);
        pins_async = v;
        repeat (DB + 6) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    int n, rcnt, fcnt, changes;
    logic [W-1:0] fval, rany, snap;
    int rem [W];

    initial begin
        // Reset and reset state
        reset = 1'b1;
        pins_async = '0;
        repeat (2) tick();
        reset = 1'b0;
        chk("reset_i_pins", 32'(i_pins), 32'd0);
        chk("reset_rise", 32'(rise_pulse), 32'd0);
        chk("reset_fall", 32'(fall_pulse), 32'd0);
        mon_en = 1'b1;

        // Scenario 1: clean rise on bit0, latency and single pulse
        tick();
        pins_async = 4'b0001;
        n = 0; rcnt = 0; fcnt = 0;
        do begin
            tick();
            n++;
            if (rise_pulse[0]) rcnt++;
            if (fall_pulse != 0) fcnt++;
        end while (!i_pins[0] && n < 20);
        chk("s1_latency_edges", 32'(n), 32'(DB + 2));
        repeat (5) begin
            tick();
            if (rise_pulse[0]) rcnt++;
            if (fall_pulse != 0) fcnt++;
        end
        chk("s1_i_pins", 32'(i_pins), 32'b0001);
        chk("s1_rise_count", 32'(rcnt), 32'd1);
        chk("s1_fall_count", 32'(fcnt), 32'd0);

        // Scenario 2: 3-cycle glitch on bit1 rejected, then 4-cycle hold accepted
        settle(4'b0000);
        chk("s2_start", 32'(i_pins), 32'd0);
        pins_async = 4'b0010;
        repeat (3) tick();
        pins_async = 4'b0000;
        rcnt = 0;
        repeat (10) begin
            tick();
            if (rise_pulse != 0 || fall_pulse != 0) rcnt++;
        end
        chk("s2_glitch_i_pins", 32'(i_pins), 32'd0);
        chk("s2_glitch_pulses", 32'(rcnt), 32'd0);
        pins_async = 4'b0010;
        rcnt = 0;
        repeat (10) begin
            tick();
            if (rise_pulse[1]) rcnt++;
        end
        chk("s2_accept_i_pins", 32'(i_pins), 32'b0010);
        chk("s2_rise1_count", 32'(rcnt), 32'd1);

        // Scenario 3: two bits fall together
        settle(4'b1111);
        chk("s3_start", 32'(i_pins), 32'b1111);
        pins_async = 4'b0101;
        fcnt = 0; fval = '0; rany = '0;
        repeat (12) begin
            tick();
            if (fall_pulse != 0) begin
                fcnt++;
                fval = fall_pulse;
            end
            rany |= rise_pulse;
        end
        chk("s3_fall_count", 32'(fcnt), 32'd1);
        chk("s3_fall_value", 32'(fval), 32'b1010);
        chk("s3_rise_none", 32'(rany), 32'd0);
        chk("s3_i_pins", 32'(i_pins), 32'b0101);

        // Scenario 4: reset mid-count discards partial count
        settle(4'b0000);
        pins_async = 4'b0001;
        repeat (4) tick();
        chk("s4_not_yet", 32'(i_pins), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("s4_after_reset", 32'(i_pins), 32'd0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!i_pins[0] && n < 20);
        chk("s4_latency_edges", 32'(n), 32'(DB + 2));

        // Scenario 6: all bits toggling with runs shorter than DB
        settle(4'b0110);
        snap = i_pins;
        chk("s6_start", 32'(snap), 32'b0110);
        for (int b = 0; b < W; b++) rem[b] = int'($urandom_range(1, DB - 1));
        changes = 0;
        repeat (1000) begin
            for (int b = 0; b < W; b++) begin
                rem[b]--;
                if (rem[b] == 0) begin
                    pins_async[b] = ~pins_async[b];
                    rem[b] = int'($urandom_range(1, DB - 1));
                end
            end
            tick();
            if (i_pins != snap || rise_pulse != 0 || fall_pulse != 0) changes++;
        end
        chk("s6_changes", 32'(changes), 32'd0);

        // Random holds long and short, checked cycle by cycle by the model
        for (int b = 0; b < W; b++) rem[b] = int'($urandom_range(1, 2 * DB));
        repeat (400) begin
            for (int b = 0; b < W; b++) begin
                rem[b]--;
                if (rem[b] == 0) begin
                    pins_async[b] = ~pins_async[b];
                    rem[b] = int'($urandom_range(1, 2 * DB));
                end
            end
            tick();
        end

`ifdef INPUT_PIN_CONDITIONER_EDGE_LATCH_EN
        // Scenario 5: set wins over clear, later clear takes one cycle
        settle(4'b0000);
        settle(4'b0100);
        chk("s5_rise_i_pins", 32'(i_pins[2]), 32'd1);
        chk("s5_flag_set", 32'(edge_flags[2]), 32'd1);
        pins_async = 4'b0000;
        repeat (DB + 1) tick();
        chk("s5_before_fall", 32'(i_pins[2]), 32'd1);
        edge_clear = 4'b0100;
        tick();
        edge_clear = '0;
        chk("s5_fall_i_pins", 32'(i_pins[2]), 32'd0);
        chk("s5_set_wins", 32'(edge_flags[2]), 32'd1);
        repeat (3) tick();
        edge_clear = 4'b0100;
        tick();
        edge_clear = '0;
        chk("s5_cleared", 32'(edge_flags[2]), 32'd0);
`endif

        tick();
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
